// File: rtl/deck_reader_pkg.sv
// Shared constants and state encoding for the deck reader and its card decoder.
package deck_reader_pkg;

  localparam int N_CARDS    = 52;
  localparam int N_RANKS    = 13;
  localparam int CARD_W     = 6;
  localparam int RANK_W     = 4;
  localparam int RANK_ACE   = 1;
  localparam int FACE_VALUE = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DECODE = 2'd3
  } state_t;

endpackage

// File: rtl/deck_reader_card_decode.sv
// Combinational card ID decoder: rank, blackjack value, ace flag and out-of-range flag.
module deck_reader_card_decode
  import deck_reader_pkg::*;
(
  input  logic [CARD_W-1:0] id_i,
  output logic [RANK_W-1:0] rank_o,
  output logic [RANK_W-1:0] value_o,
  output logic              is_ace_o,
  output logic              bad_o
);

  logic [CARD_W-1:0] rem;

  // Suit blocks are 13 wide, so one compare-subtract stage yields id mod 13.
  always_comb begin
    rem      = id_i;
    bad_o    = id_i >= CARD_W'(N_CARDS);
    rank_o   = '0;
    value_o  = '0;
    is_ace_o = 1'b0;
    if (id_i >= CARD_W'(3 * N_RANKS))      rem = id_i - CARD_W'(3 * N_RANKS);
    else if (id_i >= CARD_W'(2 * N_RANKS)) rem = id_i - CARD_W'(2 * N_RANKS);
    else if (id_i >= CARD_W'(N_RANKS))     rem = id_i - CARD_W'(N_RANKS);
    if (!bad_o) begin
      rank_o   = RANK_W'(rem) + RANK_W'(1);
      value_o  = (rank_o > RANK_W'(FACE_VALUE)) ? RANK_W'(FACE_VALUE) : rank_o;
      is_ace_o = rank_o == RANK_W'(RANK_ACE);
    end
  end

endmodule

// File: rtl/deck_reader.sv
// Deck reader: pops card IDs from the shuffled-deck RAM in order and presents them decoded.
module deck_reader
  import deck_reader_pkg::*;
#(
  parameter int DECK_SIZE = N_CARDS,
  parameter int RD_LAT    = 1,
  parameter int ADDR_W    = 6
) (
  input  logic                clk,
  input  logic                i_Reset,
  input  logic                i_Shuffled,
  input  logic                i_NewDeck,
  input  logic                i_Req,
  output logic [ADDR_W-1:0]   o_MemAddr,
  output logic                o_MemRdEn,
  input  logic [CARD_W-1:0]   i_MemData,
  output logic                o_CardValid,
  output logic [CARD_W-1:0]   o_CardId,
  output logic [RANK_W-1:0]   o_Rank,
  output logic [RANK_W-1:0]   o_Value,
  output logic                o_IsAce,
  output logic                o_BadCard,
  output logic                o_ReqRejected,
  output logic                o_Busy,
  output logic                o_Empty,
  output logic [CARD_W-1:0]   o_CardsLeft,
  output logic [1:0]          o_DbgState
);

  localparam logic [ADDR_W-1:0] DECK_END  = ADDR_W'(DECK_SIZE);
  localparam logic [1:0]        WAIT_LAST = 2'(RD_LAT - 1);

  state_t              state_q;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                pend_q;
  logic [1:0]          wait_cnt_q;
  logic [RANK_W-1:0]   dec_rank, dec_value;
  logic                dec_ace, dec_bad;

  deck_reader_card_decode u_decode (
    .id_i     (i_MemData),
    .rank_o   (dec_rank),
    .value_o  (dec_value),
    .is_ace_o (dec_ace),
    .bad_o    (dec_bad)
  );

  // Pointer as it will stand once the card being delivered is retired.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == ST_DECODE) begin
      if (pend_q)                ptr_d = '0;
      else if (ptr_q != DECK_END) ptr_d = ptr_q + ADDR_W'(1);
    end
  end

  // Handshake: i_Req is a one-cycle pulse accepted in IDLE or in the o_CardValid cycle;
  // each accepted request yields exactly one o_CardValid strobe, each refused one an
  // o_ReqRejected strobe, and a request seen while o_Busy is dropped without either.
  always_ff @(posedge clk) begin
    if (i_Reset) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      pend_q        <= 1'b0;
      wait_cnt_q    <= '0;
      o_MemAddr     <= '0;
      o_MemRdEn     <= 1'b0;
      o_CardValid   <= 1'b0;
      o_CardId      <= '0;
      o_Rank        <= '0;
      o_Value       <= '0;
      o_IsAce       <= 1'b0;
      o_BadCard     <= 1'b0;
      o_ReqRejected <= 1'b0;
      o_Busy        <= 1'b0;
    end else begin
      o_MemRdEn     <= 1'b0;
      o_CardValid   <= 1'b0;
      o_ReqRejected <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DECODE: begin
          ptr_q   <= i_NewDeck ? '0 : ptr_d;
          pend_q  <= 1'b0;
          state_q <= ST_IDLE;
          if (i_Req) begin
            if (!i_NewDeck && i_Shuffled && (ptr_d != DECK_END)) begin
              state_q   <= ST_READ;
              o_MemRdEn <= 1'b1;
              o_MemAddr <= ptr_d;
              o_Busy    <= 1'b1;
            end else begin
              o_ReqRejected <= 1'b1;
            end
          end
        end
        ST_READ: begin
          state_q    <= ST_WAIT;
          wait_cnt_q <= '0;
          pend_q     <= pend_q | i_NewDeck;
        end
        ST_WAIT: begin
          pend_q <= pend_q | i_NewDeck;
          if (wait_cnt_q == WAIT_LAST) begin
            state_q     <= ST_DECODE;
            o_Busy      <= 1'b0;
            o_CardValid <= 1'b1;
            o_CardId    <= i_MemData;
            o_Rank      <= dec_rank;
            o_Value     <= dec_value;
            o_IsAce     <= dec_ace;
            o_BadCard   <= dec_bad;
          end else begin
            wait_cnt_q <= wait_cnt_q + 2'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_Empty     = ptr_q == DECK_END;
  assign o_CardsLeft = CARD_W'(DECK_SIZE) - CARD_W'(ptr_q);
  assign o_DbgState  = state_q;

endmodule

// File: tb/tb_deck_reader.sv
// Bench for deck_reader: RD_LAT=1 and RD_LAT=3 instances, each with its own RAM model and scoreboard.
module tb_deck_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, shuffled, newdeck, req1, req3;

  logic [5:0] addr1, data1, id1, left1, addr3, data3, id3, left3;
  logic [3:0] rank1, value1, rank3, value3;
  logic       rden1, valid1, ace1, bad1, rej1, busy1, empty1;
  logic       rden3, valid3, ace3, bad3, rej3, busy3, empty3;
  logic [1:0] st1, st3;

  logic [5:0] ram1 [64];
  logic [5:0] ram3 [64];
  logic [5:0] d31, d32, d33;

  logic [15:0] exp1_q [$];
  logic [15:0] exp3_q [$];
  logic [15:0] e1, e3;

  int total = 0;
  int bad_n = 0;
  int n_valid1 = 0, n_rej1 = 0, n_rden1 = 0;
  int n_valid3 = 0, n_rej3 = 0;

  deck_reader #(.DECK_SIZE(52), .RD_LAT(1), .ADDR_W(6)) dut1 (
    .clk(clk), .i_Reset(rst), .i_Shuffled(shuffled), .i_NewDeck(newdeck), .i_Req(req1),
    .o_MemAddr(addr1), .o_MemRdEn(rden1), .i_MemData(data1), .o_CardValid(valid1),
    .o_CardId(id1), .o_Rank(rank1), .o_Value(value1), .o_IsAce(ace1), .o_BadCard(bad1),
    .o_ReqRejected(rej1), .o_Busy(busy1), .o_Empty(empty1), .o_CardsLeft(left1),
    .o_DbgState(st1)
  );

  deck_reader #(.DECK_SIZE(52), .RD_LAT(3), .ADDR_W(6)) dut3 (
    .clk(clk), .i_Reset(rst), .i_Shuffled(shuffled), .i_NewDeck(newdeck), .i_Req(req3),
    .o_MemAddr(addr3), .o_MemRdEn(rden3), .i_MemData(data3), .o_CardValid(valid3),
    .o_CardId(id3), .o_Rank(rank3), .o_Value(value3), .o_IsAce(ace3), .o_BadCard(bad3),
    .o_ReqRejected(rej3), .o_Busy(busy3), .o_Empty(empty3), .o_CardsLeft(left3),
    .o_DbgState(st3)
  );

  // RAM models; an unenabled read returns 63 so a missing rden shows up as a bad card.
  always @(posedge clk) data1 <= rden1 ? ram1[addr1] : 6'd63;
  always @(posedge clk) begin
    d31 <= rden3 ? ram3[addr3] : 6'd63;
    d32 <= d31;
    d33 <= d32;
  end
  assign data3 = d33;

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad_n++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_card(input int id);
    int r, v;
    if (id >= 52) return {1'b1, 1'b0, 4'd0, 4'd0, 6'(id)};
    r = id % 13 + 1;
    v = (r > 10) ? 10 : r;
    return {1'b0, (r == 1), 4'(v), 4'(r), 6'(id)};
  endfunction

  // Scoreboard monitors: pop and compare whenever a valid strobe is presented.
  always @(negedge clk) begin
    if (valid1 === 1'b1) begin
      n_valid1++;
      if (exp1_q.size() == 0) check("card1_unexpected", 1, 0);
      else begin
        e1 = exp1_q.pop_front();
        check("card1", int'({bad1, ace1, value1, rank1, id1}), int'(e1));
      end
    end
    if (rej1 === 1'b1) n_rej1++;
    if (rden1 === 1'b1) n_rden1++;
  end

  always @(negedge clk) begin
    if (valid3 === 1'b1) begin
      n_valid3++;
      if (exp3_q.size() == 0) check("card3_unexpected", 1, 0);
      else begin
        e3 = exp3_q.pop_front();
        check("card3", int'({bad3, ace3, value3, rank3, id3}), int'(e3));
      end
    end
    if (rej3 === 1'b1) n_rej3++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req1_go();
    req1 = 1'b1;
    tick();
    req1 = 1'b0;
  endtask

  task automatic wait_valid1();
    int n;
    n = 0;
    while (valid1 !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (valid1 !== 1'b1) check("valid1_timeout", 0, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, v0;
    rst = 1'b1; shuffled = 1'b0; newdeck = 1'b0; req1 = 1'b0; req3 = 1'b0;
    for (int i = 0; i < 64; i++) begin
      ram1[i] = 6'(i);
      ram3[i] = 6'(i);
    end
    repeat (3) tick();
    rst = 1'b0;

    // Reset values
    check("rst_addr", addr1, 0);
    check("rst_rden", rden1, 0);
    check("rst_valid", valid1, 0);
    check("rst_rej", rej1, 0);
    check("rst_busy", busy1, 0);
    check("rst_card", int'({bad1, ace1, value1, rank1, id1}), 0);
    check("rst_empty", empty1, 0);
    check("rst_left", left1, 52);

    // First card latency
    shuffled = 1'b1;
    repeat (5) tick();
    exp1_q.push_back(exp_card(0));
    req1_go();
    check("lat_rden", rden1, 1);
    check("lat_addr", addr1, 0);
    check("lat_busy", busy1, 1);
    tick();
    check("lat_early", valid1, 0);
    tick();
    check("lat_valid", valid1, 1);
    check("first_rank", rank1, 1);
    check("first_value", value1, 1);
    check("first_ace", ace1, 1);

    // Back-to-back deal of the whole deck
    for (int k = 1; k < 52; k++) begin
      wait_valid1();
      if (k == 13) begin
        check("king_rank", rank1, 13);
        check("king_value", value1, 10);
      end
      if (k == 23) begin
        check("ten_rank", rank1, 10);
        check("ten_value", value1, 10);
      end
      exp1_q.push_back(exp_card(k));
      req1_go();
      if (k == 1) begin
        check("b2b_rden", rden1, 1);
        check("left_51", left1, 51);
      end
    end
    wait_valid1();
    check("last_id", id1, 51);
    check("last_empty_pre", empty1, 0);
    check("last_left_pre", left1, 1);
    tick();
    check("empty", empty1, 1);
    check("left_0", left1, 0);

    // Request on an empty deck
    r0 = n_rden1;
    req1_go();
    check("empty_rej", rej1, 1);
    check("empty_rden", rden1, 0);
    tick();
    check("empty_rej_pulse", rej1, 0);
    check("empty_no_read", n_rden1, r0);

    // New deck in IDLE, then request while not shuffled
    newdeck = 1'b1;
    tick();
    newdeck = 1'b0;
    check("nd_left", left1, 52);
    check("nd_empty", empty1, 0);
    shuffled = 1'b0;
    req1_go();
    check("unshuf_rej", rej1, 1);
    check("unshuf_rden", rden1, 0);
    tick();
    check("unshuf_left", left1, 52);
    shuffled = 1'b1;

    // New deck during the sixth read
    for (int k = 0; k < 5; k++) begin
      exp1_q.push_back(exp_card(k));
      req1_go();
      wait_valid1();
      tick();
    end
    exp1_q.push_back(exp_card(5));
    req1_go();
    newdeck = 1'b1;
    tick();
    newdeck = 1'b0;
    wait_valid1();
    check("mid_nd_id", id1, 5);
    exp1_q.push_back(exp_card(0));
    req1_go();
    check("mid_nd_addr", addr1, 0);
    wait_valid1();
    tick();
    check("mid_nd_left", left1, 51);

    // New deck and request together: clear wins
    newdeck = 1'b1;
    req1 = 1'b1;
    tick();
    newdeck = 1'b0;
    req1 = 1'b0;
    check("nd_req_rej", rej1, 1);
    check("nd_req_rden", rden1, 0);
    check("nd_req_left", left1, 52);

    // Out-of-range card ID
    ram1[0] = 6'd60;
    exp1_q.push_back(exp_card(60));
    req1_go();
    wait_valid1();
    check("bad_flag", bad1, 1);
    check("bad_rank", rank1, 0);
    check("bad_value", value1, 0);
    tick();
    check("bad_left", left1, 51);

    // Reset while waiting on the RAM
    v0 = n_valid1;
    req1_go();
    tick();
    check("wait_state", st1, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstw_valid", valid1, 0);
    check("rstw_card", int'({bad1, ace1, value1, rank1, id1}), 0);
    check("rstw_busy", busy1, 0);
    check("rstw_left", left1, 52);
    check("rstw_empty", empty1, 0);
    check("rstw_addr", addr1, 0);
    repeat (4) tick();
    check("rstw_no_strobe", n_valid1, v0);

    // RD_LAT = 3 instance
    exp3_q.push_back(exp_card(0));
    req3 = 1'b1;
    tick();
    req3 = 1'b0;
    check("l3_rden", rden3, 1);
    tick();
    req3 = 1'b1;
    tick();
    req3 = 1'b0;
    check("l3_busy_norej", rej3, 0);
    check("l3_busy", busy3, 1);
    tick();
    check("l3_early", valid3, 0);
    tick();
    check("l3_valid", valid3, 1);
    repeat (5) tick();
    check("l3_one_strobe", n_valid3, 1);
    check("l3_rej_count", n_rej3, 0);
    check("l3_left", left3, 51);

    check("q1_drained", exp1_q.size(), 0);
    check("q3_drained", exp3_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad_n);
    $finish;
  end

endmodule
